// File: rtl/aes128_key_expand.sv
// AES-128 key schedule: expands key_i into rk0..rk10 using an external word S-box.
// Latency: rk0 one cycle after start acceptance, each later key one cycle after sbox_ready_i.
// Backpressure: none on rk_o; stalls on sbox_ready_i, aborts with err_o after SBOX_TIMEOUT cycles.
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   start_i, key_i                expansion request and cipher key (sampled in IDLE only)
//   busy_o                        expansion in progress
//   rk_valid_o, rk_idx_o, rk_o    one-cycle round-key strobe, index 0..10, key {w0,w1,w2,w3}
//   done_o, err_o                 completion pulse (with rk10), S-box timeout pulse
//   sbox_start_o, sbox_word_o     request pulse and held RotWord to the S-box provider
//   sbox_decrypt_o                always 0 (forward S-box)
//   sbox_word_i, sbox_ready_i     substituted word and completion pulse from the provider
module aes128_key_expand #(
  parameter int SBOX_TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [127:0] key_i,
  output logic         busy_o,
  output logic         rk_valid_o,
  output logic [3:0]   rk_idx_o,
  output logic [127:0] rk_o,
  output logic         done_o,
  output logic         err_o,
  output logic         sbox_start_o,
  output logic         sbox_decrypt_o,
  output logic [31:0]  sbox_word_o,
  input  logic [31:0]  sbox_word_i,
  input  logic         sbox_ready_i
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_EMIT} state_t;

  // r_tcnt holds the number of cycles elapsed since the request pulse, so the
  // abort fires when the next cycle would be the SBOX_TIMEOUT-th one.
  localparam logic [7:0] TCNT_LAST = 8'(SBOX_TIMEOUT - 1);

  state_t       r_state;
  logic [31:0]  r_w0, r_w1, r_w2, r_w3;
  logic [3:0]   r_round;
  logic [7:0]   r_tcnt;

  logic         r_busy;
  logic         r_rk_valid;
  logic [3:0]   r_rk_idx;
  logic [127:0] r_rk;
  logic         r_done;
  logic         r_err;
  logic         r_sbox_start;
  logic [31:0]  r_sbox_word;

  logic [7:0]   w_rcon;
  logic [31:0]  w_temp, w_w4, w_w5, w_w6, w_w7;

  always_comb begin
    w_rcon = 8'h00;
    case (r_round)
      4'd1:    w_rcon = 8'h01;
      4'd2:    w_rcon = 8'h02;
      4'd3:    w_rcon = 8'h04;
      4'd4:    w_rcon = 8'h08;
      4'd5:    w_rcon = 8'h10;
      4'd6:    w_rcon = 8'h20;
      4'd7:    w_rcon = 8'h40;
      4'd8:    w_rcon = 8'h80;
      4'd9:    w_rcon = 8'h1b;
      4'd10:   w_rcon = 8'h36;
      default: w_rcon = 8'h00;
    endcase
  end

  // Next four schedule words, only meaningful in the cycle sbox_ready_i is seen.
  assign w_temp = sbox_word_i ^ {w_rcon, 24'h000000};
  assign w_w4   = r_w0 ^ w_temp;
  assign w_w5   = r_w1 ^ w_w4;
  assign w_w6   = r_w2 ^ w_w5;
  assign w_w7   = r_w3 ^ w_w6;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_w0         <= '0;
      r_w1         <= '0;
      r_w2         <= '0;
      r_w3         <= '0;
      r_round      <= '0;
      r_tcnt       <= '0;
      r_busy       <= 1'b0;
      r_rk_valid   <= 1'b0;
      r_rk_idx     <= '0;
      r_rk         <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_sbox_start <= 1'b0;
      r_sbox_word  <= '0;
    end else begin
      // Pulse outputs default low; each state raises them for exactly one cycle.
      r_rk_valid   <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_sbox_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_w0         <= key_i[127:96];
            r_w1         <= key_i[95:64];
            r_w2         <= key_i[63:32];
            r_w3         <= key_i[31:0];
            r_round      <= 4'd1;
            r_tcnt       <= '0;
            r_busy       <= 1'b1;
            // rk0 and the first RotWord request appear together in REQ.
            r_rk_valid   <= 1'b1;
            r_rk_idx     <= 4'd0;
            r_rk         <= key_i;
            r_sbox_start <= 1'b1;
            r_sbox_word  <= {key_i[23:0], key_i[31:24]};
            r_state      <= S_REQ;
          end
        end
        S_REQ: begin
          r_tcnt  <= 8'd1;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // Ready takes priority over the timeout in the same cycle.
          if (sbox_ready_i) begin
            r_w0       <= w_w4;
            r_w1       <= w_w5;
            r_w2       <= w_w6;
            r_w3       <= w_w7;
            r_rk_valid <= 1'b1;
            r_rk_idx   <= r_round;
            r_rk       <= {w_w4, w_w5, w_w6, w_w7};
            if (r_round == 4'd10) begin
              r_done <= 1'b1;
            end else begin
              r_sbox_start <= 1'b1;
              r_sbox_word  <= {w_w7[23:0], w_w7[31:24]};
            end
            r_state <= S_EMIT;
          end else if (r_tcnt == TCNT_LAST) begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_tcnt  <= '0;
            r_state <= S_IDLE;
          end else begin
            r_tcnt <= r_tcnt + 8'd1;
          end
        end
        S_EMIT: begin
          if (r_round == 4'd10) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_round <= r_round + 4'd1;
            r_tcnt  <= 8'd1;
            r_state <= S_WAIT;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy_o         = r_busy;
  assign rk_valid_o     = r_rk_valid;
  assign rk_idx_o       = r_rk_idx;
  assign rk_o           = r_rk;
  assign done_o         = r_done;
  assign err_o          = r_err;
  assign sbox_start_o   = r_sbox_start;
  assign sbox_word_o    = r_sbox_word;
  assign sbox_decrypt_o = 1'b0;

endmodule

// File: tb/tb_aes128_key_expand.sv
module tb_aes128_key_expand;

  localparam int TO = 15;
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_i;
  logic [127:0] key_i;
  logic         busy_o, rk_valid_o, done_o, err_o, sbox_start_o, sbox_decrypt_o;
  logic [3:0]   rk_idx_o;
  logic [127:0] rk_o;
  logic [31:0]  sbox_word_o, sbox_word_i;
  logic         sbox_ready_i;

  aes128_key_expand #(.SBOX_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .key_i(key_i),
    .busy_o(busy_o), .rk_valid_o(rk_valid_o), .rk_idx_o(rk_idx_o), .rk_o(rk_o),
    .done_o(done_o), .err_o(err_o), .sbox_start_o(sbox_start_o),
    .sbox_decrypt_o(sbox_decrypt_o), .sbox_word_o(sbox_word_o),
    .sbox_word_i(sbox_word_i), .sbox_ready_i(sbox_ready_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait budget expired (cycle %0d)", nm, cyc);
  endtask

  // ---------------- reference model: GF(2^8) S-box and FIPS-197 key schedule
  logic [7:0] sbox_t [256];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
    for (int k = 0; k < n; k++) a = {a[6:0], a[7]};
    return a;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [7:0] b, inv;
      b   = i[7:0];
      inv = 8'h00;
      for (int j = 1; j < 256; j++)
        if (gmul(b, j[7:0]) == 8'h01) inv = j[7:0];
      sbox_t[i] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  end

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sbox_t[x[31:24]], sbox_t[x[23:16]], sbox_t[x[15:8]], sbox_t[x[7:0]]};
  endfunction

  function automatic logic [127:0] ref_rk(input logic [127:0] key, input int n);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
  endfunction

  // ---------------- scoreboard
  logic [127:0] exp_rk_q  [$];
  logic [3:0]   exp_idx_q [$];

  task automatic push_keys(input logic [127:0] key, input int count);
    for (int i = 0; i < count; i++) begin
      exp_rk_q.push_back(ref_rk(key, i));
      exp_idx_q.push_back(4'(i));
    end
  endtask

  // Known-answer values checked directly against the DUT for selected runs.
  bit           const_chk = 1'b0;
  logic [31:0]  chk_req0;
  logic [127:0] chk_rk1, chk_rk10;

  // ---------------- S-box provider model
  int   pmode = 0;          // 0: fixed 7-cycle latency, 1: random 3..12, 2: never ready
  bit   spurious_en = 1'b0;
  bit   pend = 1'b0;
  int   pcnt = 0;
  logic [31:0] pword = '0;

  initial begin
    forever begin
      @(negedge clk);
      sbox_ready_i = 1'b0;
      sbox_word_i  = $urandom;
      if (!rst_n || err_o) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          check("sbox_word_held", 128'(sbox_word_o), 128'(pword));
          if (pmode != 2) begin
            pcnt--;
            if (pcnt == 0) begin
              sbox_ready_i = 1'b1;
              sbox_word_i  = subw(sbox_word_o);
              pend = 1'b0;
            end
          end
        end else if (spurious_en && $urandom_range(0, 2) == 0) begin
          sbox_ready_i = 1'b1;
        end
        if (sbox_start_o) begin
          check("sbox_start_while_pending", 128'(pend), 128'(0));
          pend  = 1'b1;
          pword = sbox_word_o;
          pcnt  = (pmode == 1) ? int'($urandom_range(3, 12)) : 7;
        end
      end
    end
  end

  // ---------------- output monitor
  int n_done = 0;
  int n_err = 0;
  int done_cyc = 0;
  int last_start = 0;

  initial begin
    logic [127:0] e_rk;
    logic [3:0]   e_idx;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (sbox_start_o) last_start = cyc;
        if (rk_valid_o) begin
          if (exp_rk_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rk_unexpected: got idx %0d rk %h, required no strobe", rk_idx_o, rk_o);
          end else begin
            e_rk  = exp_rk_q.pop_front();
            e_idx = exp_idx_q.pop_front();
            check("rk_idx", 128'(rk_idx_o), 128'(e_idx));
            check("rk_value", rk_o, e_rk);
            check("done_with_rk10", 128'(done_o), 128'(e_idx == 4'd10));
          end
          check("sbox_decrypt", 128'(sbox_decrypt_o), 128'(0));
          if (const_chk && rk_idx_o == 4'd0) begin
            check("first_req_start", 128'(sbox_start_o), 128'(1));
            check("first_req_word", 128'(sbox_word_o), 128'(chk_req0));
          end
          if (const_chk && rk_idx_o == 4'd1)  check("kat_rk1", rk_o, chk_rk1);
          if (const_chk && rk_idx_o == 4'd10) check("kat_rk10", rk_o, chk_rk10);
        end else if (done_o) begin
          n_cmp++;
          n_bad++;
          $display("FAIL done_without_rk: got done_o=1 with rk_valid_o=0, required no done");
        end
        if (done_o) begin
          n_done++;
          done_cyc = cyc;
        end
        if (err_o) begin
          n_err++;
          check("err_delay", 128'(cyc - last_start), 128'(TO));
          check("busy_at_err", 128'(busy_o), 128'(0));
        end
      end
    end
  end

  // ---------------- stimulus
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic run_key(input logic [127:0] key, input int nkeys, output int acc_cyc);
    push_keys(key, nkeys);
    key_i   = key;
    start_i = 1'b1;
    acc_cyc = cyc;
    step();
    start_i = 1'b0;
    key_i   = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_idle(input string nm);
    bit ok = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if (!busy_o && exp_rk_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) bound_fail(nm);
    step();
  endtask

  task automatic set_kat(input bit en, input logic [31:0] r0, input logic [127:0] k1,
                         input logic [127:0] k10);
    const_chk = en;
    chk_req0  = r0;
    chk_rk1   = k1;
    chk_rk10  = k10;
  endtask

  task automatic full_run(input logic [127:0] key, input string nm);
    int acc, d0, e0;
    d0 = n_done;
    e0 = n_err;
    run_key(key, 11, acc);
    wait_idle(nm);
    check({nm, "_done_count"}, 128'(n_done - d0), 128'(1));
    check({nm, "_err_count"}, 128'(n_err - e0), 128'(0));
  endtask

  initial begin
    int acc, d0, e0, n_acc;
    logic [127:0] rkey;
    bit ok;
    rst_n = 1'b0; start_i = 1'b0; key_i = '0;
    sbox_ready_i = 1'b0; sbox_word_i = '0;
    repeat (3) step();
    check("reset_ctl", 128'({busy_o, rk_valid_o, rk_idx_o, done_o, err_o, sbox_start_o}), 128'(0));
    check("reset_rk", rk_o, 128'(0));
    check("reset_sbox_word", 128'(sbox_word_o), 128'(0));
    rst_n = 1'b1;
    step();

    // 1. FIPS-197 key, fixed-latency provider
    set_kat(1'b1, 32'hcf4f3c09, 128'ha0fafe1788542cb123a339392a6c7605,
            128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    full_run(FIPS_KEY, "fips");

    // 2. all-zero key plus start-to-done latency
    set_kat(1'b1, 32'h00000000, 128'h62636363626363636263636362636363,
            128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    d0 = n_done;
    run_key('0, 11, acc);
    wait_idle("zero");
    check("zero_done_count", 128'(n_done - d0), 128'(1));
    check("zero_latency", 128'(done_cyc - acc), 128'(81));

    // 3. provider never answers, then recovery
    set_kat(1'b0, '0, '0, '0);
    pmode = 2;
    d0 = n_done;
    e0 = n_err;
    run_key(FIPS_KEY, 1, acc);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (n_err > e0) begin ok = 1'b1; break; end
      step();
    end
    if (!ok) bound_fail("timeout_err");
    check("timeout_busy", 128'(busy_o), 128'(0));
    check("timeout_no_done", 128'(n_done - d0), 128'(0));
    check("timeout_queue", 128'(exp_rk_q.size()), 128'(0));
    pmode = 0;
    step();
    set_kat(1'b1, 32'hcf4f3c09, 128'ha0fafe1788542cb123a339392a6c7605,
            128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    full_run(FIPS_KEY, "after_timeout");

    // 4. start_i held for 200 cycles with spurious ready pulses
    set_kat(1'b0, '0, '0, '0);
    spurious_en = 1'b1;
    rkey = {$urandom, $urandom, $urandom, $urandom};
    d0 = n_done;
    n_acc = 0;
    key_i = rkey;
    start_i = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if (!busy_o) begin
        push_keys(rkey, 11);
        n_acc++;
      end
      step();
    end
    start_i = 1'b0;
    wait_idle("held_start");
    spurious_en = 1'b0;
    check("held_accept_count", 128'(n_acc), 128'(3));
    check("held_done_count", 128'(n_done - d0), 128'(n_acc));

    // 5. reset during the WAIT for round 5
    d0 = n_done;
    e0 = n_err;
    run_key(FIPS_KEY, 5, acc);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (exp_rk_q.size() == 0) begin ok = 1'b1; break; end
      step();
    end
    if (!ok) bound_fail("reset_wait_rk4");
    step();
    rst_n = 1'b0;
    step();
    check("midreset_ctl", 128'({busy_o, rk_valid_o, rk_idx_o, done_o, err_o, sbox_start_o}), 128'(0));
    check("midreset_rk", rk_o, 128'(0));
    check("midreset_sbox_word", 128'(sbox_word_o), 128'(0));
    rst_n = 1'b1;
    repeat (20) step();
    check("midreset_no_done", 128'(n_done - d0), 128'(0));
    check("midreset_no_err", 128'(n_err - e0), 128'(0));
    set_kat(1'b1, 32'hcf4f3c09, 128'ha0fafe1788542cb123a339392a6c7605,
            128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    full_run(FIPS_KEY, "after_reset");

    // 6. variable-latency provider: FIPS key and random keys
    pmode = 1;
    full_run(FIPS_KEY, "varlat_fips");
    set_kat(1'b0, '0, '0, '0);
    for (int r = 0; r < 4; r++) full_run({$urandom, $urandom, $urandom, $urandom}, "varlat_rand");
    pmode = 0;

    check("final_queue", 128'(exp_rk_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
